// File: rtl/k580vt57.sv
// ---------------------------------------------------------------------------
// k580vt57 -- four-channel DMA controller, i8257 / K580VT57 compatible subset.
//
// The controller asks the CPU for the bus (hrq/hlda). Once it owns the bus it
// arbitrates the enabled channel requests and runs fixed four-clock transfer
// cycles S1..S4. Between back-to-back transfers it keeps the bus and
// re-arbitrates. Channel 2 can be autoloaded from channel 3 when its count
// expires, so a display refresh channel can run continuously.
//
// Ports
//   clk                 system clock, all state changes on the rising edge
//   reset_n             asynchronous reset, active low
//   iaddr[3:0]          register select
//   idata[7:0]          CPU write data
//   odata[7:0]          CPU read data, combinational on iaddr
//   iwe_n               CPU write strobe, write committed on its rising edge
//   ird_n               CPU read strobe, read side effects on its rising edge
//   drq[3:0]            channel requests, bit 0 highest in fixed priority
//   dack[3:0]           one-hot channel acknowledge
//   hrq / hlda          bus hold request / acknowledge
//   aen                 controller drives the address bus
//   oaddr[15:0]         DMA memory address
//   memr_n memw_n
//   ior_n  iow_n        bus strobes, active low
//   tc                  terminal count, valid S1..S4 of the final transfer
//
// Register map
//   0,2,4,6  ADDR[n]   byte selected by the byte flip-flop (0 = low byte)
//   1,3,5,7  COUNT[n]  [13:0] transfers-1, [15:14] 01 write, 10 read, else verify
//   8        write: MODE (also clears the byte flip-flop)
//            read:  {3'b0, update, tcflag[3:0]}, tcflag cleared by the read
//   9..15    read as 0, writes ignored
// MODE: [3:0] channel enable, [4] rotating priority, [5] extended write,
//       [6] stop on terminal count, [7] autoload channel 2 from channel 3
// ---------------------------------------------------------------------------
module k580vt57 #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     iaddr,
  input  logic [7:0]     idata,
  output logic [7:0]     odata,
  input  logic           iwe_n,
  input  logic           ird_n,
  input  logic [NCH-1:0] drq,
  output logic [NCH-1:0] dack,
  output logic           hrq,
  input  logic           hlda,
  output logic           aen,
  output logic [15:0]    oaddr,
  output logic           memr_n,
  output logic           memw_n,
  output logic           ior_n,
  output logic           iow_n,
  output logic           tc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HREQ,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4
  } state_t;

  localparam logic [1:0] XFER_WRITE = 2'b01;  // I/O -> memory
  localparam logic [1:0] XFER_READ  = 2'b10;  // memory -> I/O
  localparam logic [1:0] AUTO_CH    = 2'd2;   // channel that gets reloaded
  localparam logic [1:0] AUTO_SRC   = 2'd3;   // channel holding reload values
  localparam logic [3:0] STATUS_SEL = 4'd8;

  // Programmable state
  logic [15:0]    addr_q  [NCH];
  logic [15:0]    count_q [NCH];
  logic [7:0]     mode_q;
  logic [NCH-1:0] tcflag_q;
  logic           update_q;
  logic           bff_q;

  // CPU strobe history for rising-edge detection
  logic           iwe_q;
  logic           ird_q;

  // Transfer engine
  state_t         state_q;
  logic [1:0]     cur_ch_q;
  logic [1:0]     last_ch_q;
  logic [1:0]     xfer_mode_q;

  // Combinational helpers
  logic           wr_commit;
  logic           rd_commit;
  logic [1:0]     sel;
  logic           mirror;
  logic [15:0]    rd_word;
  logic [NCH-1:0] eligible;
  logic           any_elig;
  logic [1:0]     win_ch;
  logic [NCH-1:0] win_onehot;
  logic           start;

  // A CPU access takes effect when its strobe returns high.
  assign wr_commit = iwe_n & ~iwe_q;
  assign rd_commit = ird_n & ~ird_q;

  assign sel      = iaddr[2:1];
  // Channel 2 writes are shadowed into channel 3 so the reload values follow.
  assign mirror   = mode_q[7] && (sel == AUTO_CH);
  assign rd_word  = iaddr[0] ? count_q[sel] : addr_q[sel];

  assign eligible = drq & mode_q[NCH-1:0];
  assign any_elig = |eligible;

  // A new cycle starts from HREQ, or straight from S4 while the bus is kept.
  assign start = hlda && any_elig && ((state_q == ST_HREQ) || (state_q == ST_S4));

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    odata = '0;
    if (!iaddr[3]) begin
      odata = bff_q ? rd_word[15:8] : rd_word[7:0];
    end else if (iaddr == STATUS_SEL) begin
      odata = {3'b000, update_q, tcflag_q};
    end
  end

  // Priority resolution. Candidates are visited from lowest to highest
  // priority so the last hit is the winner.
  always_comb begin
    win_ch = '0;
    if (mode_q[4]) begin
      // Rotating: the channel after the last serviced one is on top.
      for (int k = NCH; k >= 1; k--) begin
        if (eligible[2'(last_ch_q + 2'(k))]) begin
          win_ch = 2'(last_ch_q + 2'(k));
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (eligible[k]) begin
          win_ch = 2'(k);
        end
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[win_ch] = 1'b1;
  end

  // Single sequential process: the transfer engine and the CPU port both
  // modify the channel registers, and the CPU must win on a same-cycle
  // collision, so the CPU updates come last in program order.
  // NOTE: sequential state uses non-blocking assignments only; when two
  // assignments to the same bits land in one clock, the later one wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the channel register arrays are reset too: they are a handful of
      // flops, and a known zero state is part of the programming model.
      for (int i = 0; i < NCH; i++) begin
        addr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      mode_q      <= '0;
      tcflag_q    <= '0;
      update_q    <= 1'b0;
      bff_q       <= 1'b0;
      iwe_q       <= 1'b1;
      ird_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      last_ch_q   <= 2'd3;  // so channel 0 leads the first rotation
      xfer_mode_q <= '0;
      hrq         <= 1'b0;
      aen         <= 1'b0;
      dack        <= '0;
      tc          <= 1'b0;
      oaddr       <= '0;
      memr_n      <= 1'b1;
      memw_n      <= 1'b1;
      ior_n       <= 1'b1;
      iow_n       <= 1'b1;
    end else begin
      iwe_q <= iwe_n;
      ird_q <= ird_n;

      // ---------------- transfer engine ----------------
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            hrq     <= 1'b1;
            state_q <= ST_HREQ;
          end
        end

        ST_HREQ: begin
          // Requests gone before the CPU answered: withdraw.
          if (!any_elig) begin
            hrq     <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_S1: begin
          state_q <= ST_S2;
          case (xfer_mode_q)
            XFER_READ: begin
              memr_n <= 1'b0;
              iow_n  <= ~mode_q[5];
            end
            XFER_WRITE: begin
              ior_n  <= 1'b0;
              memw_n <= ~mode_q[5];
            end
            default: ;  // verify: no strobes
          endcase
        end

        ST_S2: begin
          state_q <= ST_S3;
          case (xfer_mode_q)
            XFER_READ:  iow_n  <= 1'b0;
            XFER_WRITE: memw_n <= 1'b0;
            default: ;
          endcase
        end

        ST_S3: begin
          // Registers are advanced on entry to S4 so that the exit from S4
          // arbitrates on the updated enables.
          state_q <= ST_S4;
          memr_n  <= 1'b1;
          memw_n  <= 1'b1;
          ior_n   <= 1'b1;
          iow_n   <= 1'b1;
          addr_q[cur_ch_q]        <= addr_q[cur_ch_q] + 16'd1;
          count_q[cur_ch_q][13:0] <= count_q[cur_ch_q][13:0] - 14'd1;
          if (tc) begin
            tcflag_q[cur_ch_q] <= 1'b1;
            if ((cur_ch_q == AUTO_CH) && mode_q[7]) begin
              // Autoload keeps channel 2 enabled even with TC-stop set.
              addr_q[AUTO_CH]  <= addr_q[AUTO_SRC];
              count_q[AUTO_CH] <= count_q[AUTO_SRC];
              update_q         <= 1'b1;
            end else if (mode_q[6]) begin
              mode_q[cur_ch_q] <= 1'b0;
            end
          end
        end

        ST_S4: begin
          if (!start) begin
            hrq     <= 1'b0;
            aen     <= 1'b0;
            dack    <= '0;
            tc      <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      // Entry to S1: the winner is latched and held for the whole cycle.
      if (start) begin
        state_q     <= ST_S1;
        cur_ch_q    <= win_ch;
        last_ch_q   <= win_ch;
        xfer_mode_q <= count_q[win_ch][15:14];
        aen         <= 1'b1;
        dack        <= win_onehot;
        oaddr       <= addr_q[win_ch];
        tc          <= (count_q[win_ch][13:0] == 14'd0);
        if (win_ch == AUTO_CH) begin
          update_q <= 1'b0;
        end
      end

      // ---------------- CPU register port ----------------
      if (rd_commit) begin
        if (!iaddr[3]) begin
          bff_q <= ~bff_q;
        end else if (iaddr == STATUS_SEL) begin
          tcflag_q <= '0;
        end
      end

      if (wr_commit) begin
        if (!iaddr[3]) begin
          if (!iaddr[0]) begin
            if (bff_q) begin
              addr_q[sel][15:8] <= idata;
              if (mirror) addr_q[AUTO_SRC][15:8] <= idata;
            end else begin
              addr_q[sel][7:0] <= idata;
              if (mirror) addr_q[AUTO_SRC][7:0] <= idata;
            end
          end else begin
            if (bff_q) begin
              count_q[sel][15:8] <= idata;
              if (mirror) count_q[AUTO_SRC][15:8] <= idata;
            end else begin
              count_q[sel][7:0] <= idata;
              if (mirror) count_q[AUTO_SRC][7:0] <= idata;
            end
          end
          bff_q <= ~bff_q;
        end else if (iaddr == STATUS_SEL) begin
          mode_q <= idata;
          bff_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_k580vt57.sv
// ---------------------------------------------------------------------------
// tb_k580vt57 -- self-checking bench for the k580vt57 DMA controller.
// Directed stimulus pushes the expected transfers and CPU read data into
// queues; two monitors pop and compare whenever the DUT runs a transfer
// (aen rises into S1) or the CPU reads a register.
// ---------------------------------------------------------------------------
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda;
  logic        aen;
  logic [15:0] oaddr;
  logic        memr_n, memw_n, ior_n, iow_n;
  logic        tc;
  logic        hold_en;

  always #5 clk = ~clk;

  // The CPU grants the bus as soon as it is asked, unless hold_en is off.
  assign hlda = hrq & hold_en;

  k580vt57 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .iaddr  (iaddr),
    .idata  (idata),
    .odata  (odata),
    .iwe_n  (iwe_n),
    .ird_n  (ird_n),
    .drq    (drq),
    .dack   (dack),
    .hrq    (hrq),
    .hlda   (hlda),
    .aen    (aen),
    .oaddr  (oaddr),
    .memr_n (memr_n),
    .memw_n (memw_n),
    .ior_n  (ior_n),
    .iow_n  (iow_n),
    .tc     (tc)
  );

  // Strobe vectors are {memr_n, memw_n, ior_n, iow_n}.
  localparam logic [3:0] RD_S2  = 4'b0111;  // memr low
  localparam logic [3:0] RD_S3  = 4'b0110;  // memr held, iow low
  localparam logic [3:0] WRX_S2 = 4'b1001;  // ior low, memw early (extended)
  localparam logic [3:0] WRX_S3 = 4'b1001;  // ior held, memw low

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] addr;
    logic        tc;
    logic [3:0]  s2;
    logic [3:0]  s3;
  } xfer_t;

  xfer_t      xfer_q[$];
  logic [7:0] rd_q[$];

  int checks    = 0;
  int errors    = 0;
  int xfer_done = 0;
  int s1_seen   = 0;

  logic [3:0] strobes;
  assign strobes = {memr_n, memw_n, ior_n, iow_n};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer monitor ----------------
  int          phase = 0;
  logic [3:0]  m_dack, m_s1, m_s2, m_s3;
  logic [15:0] m_addr;
  logic        m_tc1;

  always @(negedge clk) begin
    if (!reset_n) begin
      phase = 0;  // an aborted cycle is dropped
    end else begin
      case (phase)
        0: if (aen) begin
          m_dack = dack;
          m_addr = oaddr;
          m_tc1  = tc;
          m_s1   = strobes;
          s1_seen++;
          phase  = 1;
        end
        1: begin m_s2 = strobes; phase = 2; end
        2: begin m_s3 = strobes; phase = 3; end
        default: begin
          xfer_t      e;
          logic [3:0] e_dack;
          check("xfer_expected_pending", 32'(xfer_q.size() > 0), 32'd1);
          if (xfer_q.size() > 0) begin
            e      = xfer_q.pop_front();
            e_dack = 4'b0001;
            e_dack = e_dack << e.ch;
            check("xfer_dack", 32'(m_dack), 32'(e_dack));
            check("xfer_oaddr", 32'(m_addr), 32'(e.addr));
            check("xfer_tc_s1_s4", 32'({m_tc1, tc}), 32'({e.tc, e.tc}));
            check("xfer_strobes_s1_s4", 32'({m_s1, m_s2, m_s3, strobes}),
                  32'({4'hF, e.s2, e.s3, 4'hF}));
          end
          xfer_done++;
          phase = 0;
        end
      endcase
    end
  end

  // ---------------- CPU read monitor ----------------
  logic rd_seen = 1'b0;

  always @(negedge clk) begin
    if (!ird_n) begin
      if (!rd_seen) begin
        rd_seen = 1'b1;
        check("rd_expected_pending", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          check($sformatf("cpu_read_a%0d", iaddr), 32'(odata), 32'(rd_q.pop_front()));
        end
      end
    end else begin
      rd_seen = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    step();
    iaddr = a;
    idata = d;
    iwe_n = 1'b0;
    step();
    iwe_n = 1'b1;
    step();
  endtask

  task automatic prog16(input logic [3:0] a, input logic [15:0] v);
    cpu_write(a, v[7:0]);
    cpu_write(a, v[15:8]);
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp);
    step();
    iaddr = a;
    rd_q.push_back(exp);
    ird_n = 1'b0;
    step();
    ird_n = 1'b1;
    step();
  endtask

  task automatic exp_xfer(input logic [1:0] ch, input logic [15:0] a, input logic t,
                          input logic [3:0] s2, input logic [3:0] s3);
    xfer_t e;
    e.ch   = ch;
    e.addr = a;
    e.tc   = t;
    e.s2   = s2;
    e.s3   = s3;
    xfer_q.push_back(e);
  endtask

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 300 && xfer_done < target; i++) step();
    check("xfer_count_reached", 32'(xfer_done >= target), 32'd1);
  endtask

  task automatic wait_s1(input int target);
    for (int i = 0; i < 300 && s1_seen < target; i++) step();
    check("s1_count_reached", 32'(s1_seen >= target), 32'd1);
  endtask

  task automatic wait_hrq(input logic val);
    for (int i = 0; i < 50 && hrq !== val; i++) step();
    check("hrq_level", 32'(hrq), 32'(val));
  endtask

  task automatic wait_memr_low();
    for (int i = 0; i < 50 && memr_n !== 1'b0; i++) step();
    check("memr_low_seen", 32'(memr_n), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    reset_n = 1'b0;
    iaddr   = '0;
    idata   = '0;
    iwe_n   = 1'b1;
    ird_n   = 1'b1;
    drq     = '0;
    hold_en = 1'b1;

    repeat (3) step();
    check("rst_hrq_aen_tc", 32'({hrq, aen, tc}), 32'd0);
    check("rst_dack", 32'(dack), 32'd0);
    check("rst_oaddr", 32'(oaddr), 32'd0);
    check("rst_strobes", 32'(strobes), 32'hF);
    reset_n = 1'b1;
    step();

    // Reset register contents and byte flip-flop walk.
    cpu_read(4'd8, 8'h00);
    cpu_read(4'd0, 8'h00);
    cpu_read(4'd0, 8'h00);
    cpu_read(4'd12, 8'h00);

    // Byte flip-flop: low then high; a MODE write restarts at the low byte.
    prog16(4'd0, 16'h1234);
    cpu_read(4'd0, 8'h34);
    cpu_read(4'd0, 8'h12);
    cpu_write(4'd0, 8'h56);   // low byte, flip-flop now on high
    cpu_write(4'd8, 8'h00);   // restart at low byte
    cpu_write(4'd0, 8'h78);   // lands in low byte again
    cpu_write(4'd8, 8'h00);
    cpu_read(4'd0, 8'h78);
    cpu_read(4'd0, 8'h12);

    // Three read transfers on ch0 with TC-stop.
    prog16(4'd0, 16'h1234);
    prog16(4'd1, 16'h8002);
    cpu_write(4'd8, 8'h41);
    exp_xfer(2'd0, 16'h1234, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd0, 16'h1235, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd0, 16'h1236, 1'b1, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0001;
    wait_xfers(base + 3);
    wait_hrq(1'b0);
    repeat (6) step();  // drq0 still high but ch0 is now disabled
    check("tcstop_no_hrq", 32'(hrq), 32'd0);
    drq = 4'b0000;
    cpu_read(4'd8, 8'h01);
    cpu_read(4'd8, 8'h00);
    cpu_read(4'd0, 8'h37);
    cpu_read(4'd0, 8'h12);
    cpu_read(4'd1, 8'hFF);   // count wrapped to 0x3FFF, mode bits kept
    cpu_read(4'd1, 8'hBF);

    // Fixed priority: ch0 beats ch2 until ch0 hits TC.
    prog16(4'd0, 16'h2000);
    prog16(4'd1, 16'h8001);
    prog16(4'd4, 16'h3000);
    prog16(4'd5, 16'h8000);
    cpu_write(4'd8, 8'h45);
    exp_xfer(2'd0, 16'h2000, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd0, 16'h2001, 1'b1, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'h3000, 1'b1, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0101;
    wait_xfers(base + 3);
    wait_hrq(1'b0);
    drq = 4'b0000;
    cpu_read(4'd8, 8'h05);

    // Rotating priority: 0,2,0,2.
    prog16(4'd0, 16'h4000);
    prog16(4'd1, 16'h8001);
    prog16(4'd4, 16'h5000);
    prog16(4'd5, 16'h8001);
    cpu_write(4'd8, 8'h55);
    exp_xfer(2'd0, 16'h4000, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'h5000, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd0, 16'h4001, 1'b1, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'h5001, 1'b1, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0101;
    wait_xfers(base + 4);
    wait_hrq(1'b0);
    drq = 4'b0000;
    cpu_read(4'd8, 8'h05);

    // Autoload of ch2 from ch3.
    cpu_write(4'd8, 8'h84);
    prog16(4'd4, 16'hE000);
    prog16(4'd5, 16'h8003);
    exp_xfer(2'd2, 16'hE000, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'hE001, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'hE002, 1'b0, RD_S2, RD_S3);
    exp_xfer(2'd2, 16'hE003, 1'b1, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0100;
    wait_s1(s1_seen + 4);
    drq = 4'b0000;           // drq dropped after S1: the 4th transfer completes
    wait_xfers(base + 4);
    wait_hrq(1'b0);
    cpu_read(4'd8, 8'h14);
    cpu_read(4'd8, 8'h10);
    cpu_read(4'd4, 8'h00);
    cpu_read(4'd4, 8'hE0);
    cpu_read(4'd5, 8'h03);
    cpu_read(4'd5, 8'h80);
    exp_xfer(2'd2, 16'hE000, 1'b0, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0100;
    wait_s1(s1_seen + 1);
    drq = 4'b0000;
    wait_xfers(base + 1);
    wait_hrq(1'b0);
    cpu_read(4'd8, 8'h00);

    // Extended write, COUNT=0 gives exactly one transfer.
    prog16(4'd2, 16'h6000);
    prog16(4'd3, 16'h4000);
    cpu_write(4'd8, 8'h62);
    exp_xfer(2'd1, 16'h6000, 1'b1, WRX_S2, WRX_S3);
    base = xfer_done;
    drq  = 4'b0010;
    wait_xfers(base + 1);
    wait_hrq(1'b0);
    drq = 4'b0000;
    cpu_read(4'd8, 8'h02);

    // Request withdrawn while waiting for hlda.
    hold_en = 1'b0;
    cpu_write(4'd8, 8'h01);
    drq = 4'b0001;
    wait_hrq(1'b1);
    drq = 4'b0000;
    step();
    step();
    check("hreq_withdraw_hrq", 32'(hrq), 32'd0);
    check("hreq_withdraw_dack_aen", 32'({dack, aen}), 32'd0);

    // hlda dropped mid-cycle: the transfer completes, then the bus is freed.
    hold_en = 1'b1;
    prog16(4'd0, 16'h7000);
    prog16(4'd1, 16'h8005);
    exp_xfer(2'd0, 16'h7000, 1'b0, RD_S2, RD_S3);
    base = xfer_done;
    drq  = 4'b0001;
    wait_memr_low();
    hold_en = 1'b0;
    wait_xfers(base + 1);
    step();
    check("hlda_drop_aen_dack", 32'({dack, aen}), 32'd0);
    drq = 4'b0000;
    step();
    step();
    check("hlda_drop_hrq", 32'(hrq), 32'd0);

    // Asynchronous reset during S2.
    hold_en = 1'b1;
    drq     = 4'b0001;
    wait_memr_low();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_strobes", 32'(strobes), 32'hF);
    check("midrst_hrq_aen_tc", 32'({hrq, aen, tc}), 32'd0);
    check("midrst_dack_oaddr", 32'({dack, oaddr}), 32'd0);
    drq = 4'b0000;
    step();
    reset_n = 1'b1;
    step();
    cpu_read(4'd0, 8'h00);
    cpu_read(4'd8, 8'h00);

    repeat (4) step();
    check("xfer_queue_drained", 32'(xfer_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/k580vt57.md
Name: k580vt57

Overview:
- 4-channel DMA controller (i8257 / K580VT57 compatible subset).
- Requests the CPU bus with a hold handshake, then arbitrates the channel DRQs and runs fixed 4-state transfer cycles.
- In the system, channel 2 feeds the CRT controller's drq/dack pair; channel 3 holds the autoload values for channel 2.
- CPU programs it through an 8-bit register port.

Parameters:
- NCH, 4: number of channels. Fixed at 4; the register map depends on it.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- iaddr  in  4  register select.
- idata  in  8  CPU write data.
- odata  out  8  CPU read data; combinational mux of iaddr.
- iwe_n  in  1  CPU write strobe; the write is committed on its rising edge (iwe_n=1 while the registered copy is 0).
- ird_n  in  1  CPU read strobe; read side effects occur on its rising edge.
- drq  in  4  channel requests; bit 0 is highest in fixed priority.
- dack  out  4  one-hot channel acknowledge.
- hrq  out  1  bus hold request to the CPU.
- hlda  in  1  hold acknowledge from the CPU.
- aen  out  1  controller owns the address bus.
- oaddr  out  16  DMA memory address.
- memr_n, memw_n, ior_n, iow_n  out  1 each  bus strobes.
- tc  out  1  terminal count, valid during S1..S4 of the last transfer.

Behaviour:
- Reset values:
  - hrq, aen, dack, tc = 0; oaddr = 0; all strobes = 1.
  - Mode register = 0; address, count and status registers = 0; byte flip-flop (bff) = 0; FSM in IDLE.
- Reset mid-transfer forces the same state immediately.
- Register map:
  - Even iaddr 0..6: ADDR[n], n = iaddr>>1.
  - Odd iaddr 1..7: COUNT[n]. Bits 13:0 hold count (transfers − 1). Bits 15:14 are mode: 01 = write (ior + memw), 10 = read (memr + iow), 00 or 11 = verify (no strobes).
  - bff=0 selects the low byte and bff=1 the high byte. Every read or write of addresses 0..7 toggles bff.
  - Write to iaddr 8 loads MODE and clears bff. MODE bits: [3:0] channel enable, [4] rotating priority, [5] extended write, [6] TC-stop, [7] autoload.
  - Read of iaddr 8 returns {3'b0, update, tcflag[3:0]}. tcflag is cleared on the rising edge of ird_n.
  - iaddr 9..15 reads 0; writes to it are ignored.
  - Autoload:
    - A write to ADDR[2] or COUNT[2] also writes the same byte to channel 3 when MODE[7]=1.
- Arbitration:
  - Eligible channels are drq & MODE[3:0].
  - Fixed mode: lowest index wins.
  - Rotating mode: the channel after the last serviced one has top priority; last serviced resets to 3, so ch0 is first.
  - The winner is latched on entry to S1 and held for the whole cycle.
- FSM, one state per clk:
  - IDLE: any eligible → hrq=1, go to HREQ.
  - HREQ: no eligible → hrq=0, go to IDLE. hlda=1 → go to S1.
  - S1: aen=1; dack[ch]=1; oaddr=ADDR[ch]; tc=(COUNT[ch][13:0]==0).
  - S2: read-type strobe low (memr_n for read, ior_n for write); with MODE[5], the write-type strobe is also low.
  - S3: write-type strobe low (iow_n or memw_n), read strobe held.
  - S4: all strobes high. ADDR+=1 (16-bit wrap). COUNT[13:0]−=1 (14-bit wrap, mode bits kept). If tc: set tcflag[ch]; if MODE[6], clear MODE[ch].
    - If ch==2 and MODE[7]: reload ADDR[2]/COUNT[2] from ch3, keep ch2 enabled, set update. update clears on the next S1 of ch2.
  - After S4: dack=0 and tc=0. If hlda and any eligible → S1 (re-arbitrate); else hrq=0, aen=0, go to IDLE.
- Boundary cases:
  - hlda dropping during S1..S4: the cycle completes, then the controller releases the bus.
  - drq dropping after S1: the transfer still completes.
  - CPU write to the same register in the S4 update cycle: the CPU write wins.
  - Only one dack bit is ever high.
  - COUNT=0 transfers exactly 1 byte.

Test Plan:
- Program ADDR0=0x1234, COUNT0=0x8002, MODE=0x41; hold drq0 with hlda echoing hrq → 3 read cycles at oaddr 0x1234..0x1236, memr_n/iow_n pulsed each time, tc only on the 3rd, tcflag=0x01, MODE[0]=0 afterward, status read then returns 0.
- drq0 and drq2 both high in fixed mode → ch0 serviced every cycle. In rotating mode → services alternate 0,2,0,2.
- Autoload: program ch2 ADDR=0xE000, COUNT=0x8003, MODE=0x84 → 4 transfers, then ADDR2 reloads to 0xE000, ch2 stays enabled, status update bit reads 1 until the next ch2 S1.
- Write-mode COUNT=0x4000 with MODE[5]=1 → memw_n low in both S2 and S3; ior_n low in S2..S3; 1 transfer.
- drq dropped while in HREQ → hrq returns to 0 and no dack is issued. Assert reset_n=0 during S2 → all strobes high, aen=0, hrq=0 immediately.
- Byte flip-flop: write 0x34 then 0x12 to iaddr 0 → ADDR0 reads back 0x34, 0x12. A MODE write between the two bytes restarts at the low byte.
